// File: rtl/alu_op_dispatch.sv
// Registered ALU operation dispatcher: accepts an op, fires a one-hot unit enable,
// then waits for that unit's done flag with illegal-op and timeout detection.
module alu_op_dispatch #(
    parameter int                       FUN_W     = 4,
    parameter int                       SEL_W     = 2,
    parameter int                       DATA_W    = 16,
    parameter logic [(2**SEL_W)-1:0]    UNIT_MASK = '1,
    parameter int                       TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [FUN_W-1:0]            alu_fun_i,
    input  logic [DATA_W-1:0]           a_i,
    input  logic [DATA_W-1:0]           b_i,
    output logic [(2**SEL_W)-1:0]       unit_en_o,
    output logic [FUN_W-SEL_W-1:0]      unit_fun_o,
    output logic [DATA_W-1:0]           opa_o,
    output logic [DATA_W-1:0]           opb_o,
    input  logic [(2**SEL_W)-1:0]       unit_done_i,
    output logic                        cmpl_valid_o,
    output logic [SEL_W-1:0]            cmpl_unit_o,
    output logic                        err_illegal_o,
    output logic                        err_timeout_o,
    output logic                        busy_o
);

    localparam int NUM_UNITS = 2**SEL_W;
    localparam int SUB_W     = FUN_W - SEL_W;
    localparam bit TO_EN     = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SUB_W-1:0]       sub_q, sub_d;
    logic [DATA_W-1:0]      opa_q, opa_d;
    logic [DATA_W-1:0]      opb_q, opb_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   cmpl_valid_q, cmpl_valid_d;
    logic [SEL_W-1:0]       cmpl_unit_q, cmpl_unit_d;
    logic                   err_ill_q, err_ill_d;
    logic                   err_to_q, err_to_d;

    logic [SEL_W-1:0]       selIn;
    logic                   doneSel;
    logic                   timeoutHit;

    assign selIn      = alu_fun_i[FUN_W-1 -: SEL_W];
    assign doneSel    = unit_done_i[sel_q];
    assign timeoutHit = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sub_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            cmpl_valid_q <= 1'b0;
            cmpl_unit_q  <= '0;
            err_ill_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sub_q        <= sub_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            cnt_q        <= cnt_d;
            cmpl_valid_q <= cmpl_valid_d;
            cmpl_unit_q  <= cmpl_unit_d;
            err_ill_q    <= err_ill_d;
            err_to_q     <= err_to_d;
        end
    end

    // Status pulses are computed here so they land one cycle after the deciding edge.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sub_d        = sub_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        cnt_d        = cnt_q;
        cmpl_valid_d = 1'b0;
        cmpl_unit_d  = '0;
        err_ill_d    = 1'b0;
        err_to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sel_d = selIn;
                    sub_d = alu_fun_i[SUB_W-1:0];
                    opa_d = a_i;
                    opb_d = b_i;
                    cnt_d = '0;
                    if (UNIT_MASK[selIn]) begin
                        state_d = ISSUE;
                    end else begin
                        err_ill_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (doneSel) begin
                    state_d      = IDLE;
                    cmpl_valid_d = 1'b1;
                    cmpl_unit_d  = sel_q;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A done arriving on the timeout edge still counts as a completion.
                if (doneSel) begin
                    state_d      = IDLE;
                    cmpl_valid_d = 1'b1;
                    cmpl_unit_d  = sel_q;
                end else if (timeoutHit) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == IDLE);
        busy_o     = (state_q != IDLE);
        unit_en_o  = '0;
        if (state_q == ISSUE) begin
            unit_en_o = {{(NUM_UNITS-1){1'b0}}, 1'b1} << sel_q;
        end
    end

    assign unit_fun_o    = sub_q;
    assign opa_o         = opa_q;
    assign opb_o         = opb_q;
    assign cmpl_valid_o  = cmpl_valid_q;
    assign cmpl_unit_o   = cmpl_unit_q;
    assign err_illegal_o = err_ill_q;
    assign err_timeout_o = err_to_q;

endmodule

// File: doc/alu_op_dispatch.md
# alu_op_dispatch

Registered, parametrised successor to the ALU function decoder. It accepts an operation (function code plus two operands) over a valid/ready handshake and decodes the upper select bits into a one-cycle one-hot unit enable. It holds the operands and sub-function stable while the selected unit works, then waits for that unit's done flag. Sits between the ALU front end and the arithmetic, logic, compare and shift units, and adds illegal-op and timeout detection.

## Interface
- FUN_W, 4, total function-code width
- SEL_W, 2, upper FUN bits selecting the unit; NUM_UNITS = 2**SEL_W
- DATA_W, 16, operand width
- UNIT_MASK, all ones (NUM_UNITS bits), bit i = 1 means unit i is implemented
- TIMEOUT, 16, maximum wait cycles for done; 0 disables the timeout (range 0..255)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operation offered
- IN_READY  out  1  dispatcher can accept
- ALU_FUN  in  FUN_W  function code
- A, B  in  DATA_W  operands
- UNIT_EN  out  NUM_UNITS  one-hot issue pulse
- UNIT_FUN  out  FUN_W-SEL_W  sub-function, i.e. ALU_FUN[FUN_W-SEL_W-1:0] as captured
- OPA, OPB  out  DATA_W  captured operands
- UNIT_DONE  in  NUM_UNITS  per-unit completion flags
- CMPL_VALID  out  1  completion pulse
- CMPL_UNIT  out  SEL_W  index of the unit that completed
- ERR_ILLEGAL  out  1  pulse: op addressed a masked unit
- ERR_TIMEOUT  out  1  pulse: unit did not finish in time
- BUSY  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - IN_READY = 1.
  - On IN_VALID, capture ALU_FUN, A and B. The captured select is sel = ALU_FUN[FUN_W-1:FUN_W-SEL_W].
  - If UNIT_MASK[sel] = 0: pulse ERR_ILLEGAL for one cycle, stay in IDLE, and do not drive UNIT_EN.
  - Otherwise go to ISSUE.
- ISSUE:
  - UNIT_EN = 1 << sel for exactly this cycle; IN_READY = 0.
  - If UNIT_DONE[sel] = 1, complete and return to IDLE; otherwise go to WAIT.
- WAIT:
  - UNIT_EN = 0.
  - If UNIT_DONE[sel] = 1, complete and return to IDLE.
  - Else, if TIMEOUT != 0 and the wait count equals TIMEOUT-1, pulse ERR_TIMEOUT and return to IDLE.
  - Else increment the wait count.
- Complete: registered CMPL_VALID = 1 and CMPL_UNIT = sel for one cycle.
- UNIT_DONE bits of non-selected units are ignored in every state. All of UNIT_DONE is ignored in IDLE.
- Wait count: 8 bits, cleared on every accept.
- OPA, OPB and UNIT_FUN change only on accept; they hold their values through ISSUE, WAIT and IDLE.
- BUSY = (state != IDLE).

## Timing
- Reset (RST low, asynchronous): state IDLE. All outputs 0 except IN_READY = 1. This includes UNIT_EN, OPA, OPB, UNIT_FUN, CMPL_*, ERR_* and the wait count.
- Reset mid-operation returns to IDLE immediately. No completion or error pulse is issued for the aborted op.
- Accept: handshake at edge k; UNIT_EN is high during cycle k+1.
- Minimum latency: done seen in ISSUE gives CMPL_VALID in cycle k+2. Next accept is possible at edge k+2, so best case is one op every 2 cycles.
- A done seen in WAIT at edge m gives CMPL_VALID in cycle m+1, and IN_READY is high in the same cycle.
- Illegal op: accepted at edge k, ERR_ILLEGAL high in cycle k+1, IN_READY remains 1. Back-to-back illegal ops each produce a pulse.
- Timeout: a unit that never finishes raises ERR_TIMEOUT at exactly cycle k+2+TIMEOUT.
- Done and timeout at the same edge: done wins; CMPL_VALID = 1, ERR_TIMEOUT = 0.
- IN_VALID while IN_READY = 0 has no effect. The producer must hold its data until accepted.

## Test plan
- Reset then single op: ALU_FUN=4'b0110, A=16'h1234, B=16'h00FF; UNIT_DONE[1] tied high.
  - Cycle k+1: UNIT_EN=4'b0010, UNIT_FUN=2'b10, OPA=16'h1234.
  - Cycle k+2: CMPL_VALID=1, CMPL_UNIT=1.
- Multi-cycle unit: op 4'b1100; UNIT_DONE[3] pulsed 5 cycles after issue, with UNIT_DONE[0] held high throughout.
  - One UNIT_EN pulse (4'b1000); operands stable throughout.
  - CMPL_VALID one cycle after the DONE[3] edge; UNIT_DONE[0] ignored.
- Illegal: UNIT_MASK=4'b0111, op 4'b1101 -> ERR_ILLEGAL for one cycle, UNIT_EN stays 0, BUSY stays 0, IN_READY stays 1.
- Timeout: TIMEOUT=4, op 4'b1000, no done -> ERR_TIMEOUT at cycle k+6, IN_READY=1 next, no CMPL_VALID. Repeat with DONE[2] arriving on the timeout edge -> CMPL_VALID only.
- Reset mid-WAIT: RST low two cycles after issue -> all outputs reset immediately; after release IN_READY=1 and no spurious pulses.
- Back-to-back: 8 ops with IN_VALID held high and all units' DONE tied high -> one accept every 2 cycles, 8 CMPL_VALID pulses in order with matching CMPL_UNIT.
